// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types for the memory stage: widths, FSM states and
// the registered writeback bundle handed to MEM/WB.
package mem_stage_ctrl_pkg;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HALT
    } state_t;

    typedef struct packed {
        logic              valid;
        logic              en;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
        logic              dump;
        logic              err;
    } wb_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/done bus between the memory stage and the memory.
// master: mem_req, mem_wr, mem_addr, mem_wdata out; mem_rdata, mem_done in.
interface mem_stage_ctrl_if;
    import mem_stage_ctrl_pkg::*;

    logic              mem_req;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;

    modport master (
        output mem_req,
        output mem_wr,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_done
    );

    modport slave (
        input  mem_req,
        input  mem_wr,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_done
    );

endinterface

// File: rtl/mem_stage_ctrl_ctr.sv
// Clear/enable wait counter; tc is high once the count equals TIMEOUT.
// Ports: clk, rst (async active-low), clr, en in; tc out.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 15,
    localparam int W = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == W'(TIMEOUT));

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage: issues data-memory accesses, stalls upstream while one is
// outstanding, and registers the writeback bundle for MEM/WB.
// Ports: clk, rst (async active-low), EX/MEM inputs (*_in), stall_out,
// mem (request/done bus, master side), registered wb outputs and halted.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic                mem_to_reg_in,
    input  logic                mem_write_in,
    input  logic                reg_wr_en_in,
    input  logic [SEL_W-1:0]    reg_wr_sel_in,
    input  logic [DATA_W-1:0]   result_in,
    input  logic [DATA_W-1:0]   B_in,
    input  logic                dump_in,
    output logic                stall_out,
    mem_stage_ctrl_if.master    mem,
    output logic                valid_out,
    output logic                wb_en,
    output logic [SEL_W-1:0]    wb_sel,
    output logic [DATA_W-1:0]   wb_data,
    output logic                dump_out,
    output logic                err_out,
    output logic                halted
);

    state_t           state;
    wb_t              wb_q;
    logic [SEL_W-1:0] lat_sel;
    logic             lat_load;
    logic             lat_en;
    logic             mem_op;
    logic             misal;
    logic             in_wait;
    logic             tc;
    logic             ctr_clr;

    assign mem_op  = valid_in & (mem_to_reg_in | mem_write_in);
    assign misal   = result_in[0];
    assign in_wait = (state == WAIT);

    // Count only in WAIT; a completion or abort restarts from zero.
    assign ctr_clr = ~in_wait | mem.mem_done | tc;

    mem_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_ctr (
        .clk(clk),
        .rst(rst),
        .clr(ctr_clr),
        .en (in_wait),
        .tc (tc)
    );

    // Dump takes priority over a memory op, matching the state update.
    always_comb begin
        stall_out = 1'b0;
        case (state)
            IDLE:    stall_out = mem_op & ~dump_in & ~misal;
            WAIT:    stall_out = ~mem.mem_done & ~tc;
            HALT:    stall_out = 1'b1;
            default: stall_out = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            wb_q          <= '0;
            lat_sel       <= '0;
            lat_load      <= 1'b0;
            lat_en        <= 1'b0;
            halted        <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_wr    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            mem.mem_req <= 1'b0;
            wb_q.valid  <= 1'b0;
            wb_q.en     <= 1'b0;
            wb_q.dump   <= 1'b0;
            wb_q.err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!valid_in) begin
                        state <= IDLE;
                    end else if (dump_in) begin
                        wb_q.valid <= 1'b1;
                        wb_q.en    <= reg_wr_en_in;
                        wb_q.sel   <= reg_wr_sel_in;
                        wb_q.data  <= result_in;
                        wb_q.dump  <= 1'b1;
                        halted     <= 1'b1;
                        state      <= HALT;
                    end else if (mem_op && misal) begin
                        wb_q.valid <= 1'b1;
                        wb_q.err   <= 1'b1;
                    end else if (mem_op) begin
                        state         <= WAIT;
                        mem.mem_req   <= 1'b1;
                        mem.mem_wr    <= mem_write_in;
                        mem.mem_addr  <= result_in;
                        mem.mem_wdata <= B_in;
                        lat_sel       <= reg_wr_sel_in;
                        lat_load      <= ~mem_write_in;
                        lat_en        <= reg_wr_en_in;
                    end else begin
                        wb_q.valid <= 1'b1;
                        wb_q.en    <= reg_wr_en_in;
                        wb_q.sel   <= reg_wr_sel_in;
                        wb_q.data  <= result_in;
                    end
                end
                WAIT: begin
                    if (mem.mem_done) begin
                        state      <= IDLE;
                        wb_q.valid <= 1'b1;
                        wb_q.sel   <= lat_sel;
                        if (lat_load) begin
                            wb_q.en   <= lat_en;
                            wb_q.data <= mem.mem_rdata;
                        end else begin
                            wb_q.data <= mem.mem_addr;
                        end
                    end else if (tc) begin
                        state      <= IDLE;
                        wb_q.valid <= 1'b1;
                        wb_q.err   <= 1'b1;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign valid_out = wb_q.valid;
    assign wb_en     = wb_q.en;
    assign wb_sel    = wb_q.sel;
    assign wb_data   = wb_q.data;
    assign dump_out  = wb_q.dump;
    assign err_out   = wb_q.err;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: vector table for single-cycle
// retirements plus sequences for memory, timeout, reset and halt.
module tb_mem_stage_ctrl;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        mem_to_reg_in;
    logic        mem_write_in;
    logic        reg_wr_en_in;
    logic [2:0]  reg_wr_sel_in;
    logic [15:0] result_in;
    logic [15:0] B_in;
    logic        dump_in;
    logic        stall_out;
    logic        valid_out;
    logic        wb_en;
    logic [2:0]  wb_sel;
    logic [15:0] wb_data;
    logic        dump_out;
    logic        err_out;
    logic        halted;

    int n_vec;
    int n_err;
    int n;

    mem_stage_ctrl_if mif ();

    mem_stage_ctrl #(
        .TIMEOUT(15)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .mem_to_reg_in(mem_to_reg_in),
        .mem_write_in (mem_write_in),
        .reg_wr_en_in (reg_wr_en_in),
        .reg_wr_sel_in(reg_wr_sel_in),
        .result_in    (result_in),
        .B_in         (B_in),
        .dump_in      (dump_in),
        .stall_out    (stall_out),
        .mem          (mif.master),
        .valid_out    (valid_out),
        .wb_en        (wb_en),
        .wb_sel       (wb_sel),
        .wb_data      (wb_data),
        .dump_out     (dump_out),
        .err_out      (err_out),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic        ld;
        logic        st;
        logic        en;
        logic [2:0]  sel;
        logic [15:0] res;
        logic [15:0] b;
        logic        e_stall;
        logic        e_vld;
        logic        e_en;
        logic        e_err;
        logic [2:0]  e_sel;
        logic [15:0] e_data;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic ld, input logic st,
                         input logic en, input logic [2:0] sel,
                         input logic [15:0] res, input logic [15:0] b);
        valid_in      = v;
        mem_to_reg_in = ld;
        mem_write_in  = st;
        reg_wr_en_in  = en;
        reg_wr_sel_in = sel;
        result_in     = res;
        B_in          = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        dump_in = 1'b0;
        mif.mem_done = 1'b0;
        mif.mem_rdata = 16'h0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);

        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 16'h1234, 16'h0,
                  1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 16'h1234};
        vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 16'h0001, 16'h0,
                  1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 16'h0001};
        vt[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 16'h0003, 16'h0,
                  1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 16'h0001};
        vt[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 16'h0007, 16'h9999,
                  1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 16'h0001};
        vt[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 16'hFFFF, 16'h0,
                  1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 16'h0001};
        vt[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 16'hFFFF, 16'h0,
                  1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 16'hFFFF};

        step();
        chk("rst_valid", valid_out, 0);
        chk("rst_req", mif.mem_req, 0);
        chk("rst_addr", mif.mem_addr, 0);
        chk("rst_wdata", mif.mem_wdata, 0);
        chk("rst_data", wb_data, 0);
        chk("rst_halted", halted, 0);
        chk("rst_stall", stall_out, 0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            drive(vt[i].vld, vt[i].ld, vt[i].st, vt[i].en,
                  vt[i].sel, vt[i].res, vt[i].b);
            #1;
            chk($sformatf("v%0d_stall", i), stall_out, vt[i].e_stall);
            step();
            chk($sformatf("v%0d_valid", i), valid_out, vt[i].e_vld);
            chk($sformatf("v%0d_en", i), wb_en, vt[i].e_en);
            chk($sformatf("v%0d_err", i), err_out, vt[i].e_err);
            chk($sformatf("v%0d_sel", i), wb_sel, vt[i].e_sel);
            chk($sformatf("v%0d_data", i), wb_data, vt[i].e_data);
            chk($sformatf("v%0d_req", i), mif.mem_req, 0);
        end
        valid_in = 1'b0;
        step();

        // load, done three cycles after the request
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 16'h0040, 16'h1111);
        #1;
        chk("ld_acc_stall", stall_out, 1);
        step();
        valid_in = 1'b0;
        chk("ld_req", mif.mem_req, 1);
        chk("ld_addr", mif.mem_addr, 16'h0040);
        chk("ld_wr", mif.mem_wr, 0);
        chk("ld_w1_stall", stall_out, 1);
        step();
        chk("ld_req_pulse", mif.mem_req, 0);
        chk("ld_w2_stall", stall_out, 1);
        step();
        chk("ld_w3_stall", stall_out, 1);
        step();
        mif.mem_done = 1'b1;
        mif.mem_rdata = 16'hBEEF;
        #1;
        chk("ld_done_stall", stall_out, 0);
        step();
        mif.mem_done = 1'b0;
        chk("ld_valid", valid_out, 1);
        chk("ld_data", wb_data, 16'hBEEF);
        chk("ld_en", wb_en, 1);
        chk("ld_sel", wb_sel, 4);
        chk("ld_err", err_out, 0);
        step();
        chk("ld_valid_once", valid_out, 0);

        // load+store together acts as a store; done in first WAIT cycle
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd6, 16'h0010, 16'hA5A5);
        step();
        valid_in = 1'b0;
        chk("st_req", mif.mem_req, 1);
        chk("st_wr", mif.mem_wr, 1);
        chk("st_wdata", mif.mem_wdata, 16'hA5A5);
        chk("st_addr", mif.mem_addr, 16'h0010);
        mif.mem_done = 1'b1;
        #1;
        chk("st_done_stall", stall_out, 0);
        step();
        mif.mem_done = 1'b0;
        chk("st_valid", valid_out, 1);
        chk("st_en", wb_en, 0);
        chk("st_data", wb_data, 16'h0010);
        chk("st_sel", wb_sel, 6);
        step();

        // timeout with no done
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 16'h0020, 16'h0);
        step();
        valid_in = 1'b0;
        n = 0;
        while (stall_out === 1'b1 && n < 40) begin
            n++;
            step();
        end
        chk("to_wait_cycles", n, 15);
        step();
        chk("to_valid", valid_out, 1);
        chk("to_err", err_out, 1);
        chk("to_en", wb_en, 0);
        step();
        chk("to_err_once", err_out, 0);
        chk("to_idle_stall", stall_out, 0);

        // done on the timeout cycle wins
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 16'h0022, 16'h0);
        step();
        valid_in = 1'b0;
        repeat (15) step();
        mif.mem_done = 1'b1;
        mif.mem_rdata = 16'h1357;
        #1;
        chk("tod_stall", stall_out, 0);
        step();
        mif.mem_done = 1'b0;
        chk("tod_valid", valid_out, 1);
        chk("tod_err", err_out, 0);
        chk("tod_data", wb_data, 16'h1357);
        chk("tod_en", wb_en, 1);
        step();

        // reset mid-WAIT, then a late done
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 16'h0044, 16'h0);
        step();
        valid_in = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("mr_req", mif.mem_req, 0);
        chk("mr_addr", mif.mem_addr, 0);
        chk("mr_stall", stall_out, 0);
        chk("mr_data", wb_data, 0);
        step();
        rst = 1'b1;
        mif.mem_done = 1'b1;
        mif.mem_rdata = 16'hDEAD;
        #1;
        chk("mr_late_stall", stall_out, 0);
        step();
        chk("mr_late_valid", valid_out, 0);
        chk("mr_late_data", wb_data, 0);
        mif.mem_done = 1'b0;
        step();

        // dump then halt
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 16'h00AA, 16'h0);
        dump_in = 1'b1;
        #1;
        chk("dp_stall", stall_out, 0);
        step();
        chk("dp_dump", dump_out, 1);
        chk("dp_halted", halted, 1);
        chk("dp_valid", valid_out, 1);
        chk("dp_data", wb_data, 16'h00AA);
        dump_in = 1'b0;
        result_in = 16'h5555;
        #1;
        chk("hl_stall", stall_out, 1);
        step();
        chk("hl_valid", valid_out, 0);
        chk("hl_dump", dump_out, 0);
        chk("hl_halted", halted, 1);
        chk("hl_data", wb_data, 16'h00AA);
        mif.mem_done = 1'b1;
        step();
        chk("hl_done_valid", valid_out, 0);
        chk("hl_done_stall", stall_out, 1);
        mif.mem_done = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory stage of the 5-stage 16-bit pipeline, sitting between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Consumes the EX/MEM outputs: ALU result (used as the address), store data, write-select, load/store/dump controls.
- Drives a multi-cycle request/done data-memory interface and stalls upstream while an access is outstanding.
- Produces a registered writeback bundle for MEM/WB, and flags misaligned and timed-out accesses.

Parameters:
- DATA_W, 16, datapath and address width
- SEL_W, 3, register write-select width
- TIMEOUT, 15, maximum WAIT cycles before an access is aborted with an error; legal range 1..255

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-low
- valid_in  in  1  EX/MEM holds a valid instruction
- mem_to_reg_in  in  1  load
- mem_write_in  in  1  store
- reg_wr_en_in  in  1  instruction writes the register file
- reg_wr_sel_in  in  SEL_W  destination register
- result_in  in  DATA_W  ALU result / memory address
- B_in  in  DATA_W  store data
- dump_in  in  1  halt/dump instruction
- stall_out  out  1  combinational; holds EX/MEM and all earlier stages
- mem_req  out  1  one-cycle request pulse
- mem_wr  out  1  1 = write; held stable through WAIT
- mem_addr  out  DATA_W  held stable through WAIT
- mem_wdata  out  DATA_W  held stable through WAIT
- mem_rdata  in  DATA_W  read data; valid only when mem_done=1
- mem_done  in  1  access complete
- valid_out  out  1  registered; MEM/WB bundle valid
- wb_en  out  1  registered register-file write enable
- wb_sel  out  SEL_W  registered destination register
- wb_data  out  DATA_W  registered writeback data
- dump_out  out  1  registered halt indication
- err_out  out  1  registered one-cycle error flag; qualified by valid_out
- halted  out  1  registered sticky halt flag

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; counter 0; all outputs 0, including mem_req, mem_addr, mem_wdata, halted and registered outputs. Reset asserted during WAIT abandons the access; a late mem_done after reset release is ignored.
- A memory op is valid_in & (mem_to_reg_in | mem_write_in). If both load and store are set, the op is treated as a store.
- State IDLE, non-memory valid op: next cycle valid_out=1, wb_data=result_in, wb_en=reg_wr_en_in, wb_sel=reg_wr_sel_in, dump_out=dump_in. Latency is 1 cycle and there is no stall.
- State IDLE, dump_in=1: passes through as a non-memory op, and halted is set the same edge. Once halted, stall_out=1 permanently and valid_out=0 until reset.
- State IDLE, memory op with result_in[0]=1 (misaligned): no request is issued. Next cycle valid_out=1, err_out=1, wb_en=0. No stall.
- State IDLE, aligned memory op:
  - stall_out=1 combinationally.
  - Next edge: state WAIT; mem_req=1 for exactly that first WAIT cycle; mem_addr=result_in; mem_wdata=B_in; mem_wr=store.
  - The destination register, load flag and reg_wr_en are latched for use at completion.
- State WAIT:
  - stall_out = ~mem_done.
  - mem_done is honoured from the first WAIT cycle onward; the memory must not assert it before that.
  - On mem_done: next cycle valid_out=1, state IDLE, counter cleared. For a load: wb_data=mem_rdata, wb_en=latched reg_wr_en. For a store: wb_en=0, wb_data=address.
  - Minimum memory-op latency is 2 cycles from acceptance to valid_out.
- Timeout: the counter increments each WAIT cycle without mem_done. On reaching TIMEOUT: next cycle valid_out=1, err_out=1, wb_en=0, state IDLE, stall released that cycle.
- mem_done and timeout in the same cycle: done wins and no error is raised.
- valid_out, err_out and dump_out are single-cycle per retired instruction. With no retirement in a cycle, valid_out=0 and wb_en=0, while wb_data and wb_sel hold their values.
- mem_done in IDLE or while halted: ignored.

Decomposition:
- Shared package: state enum (IDLE, WAIT, HALT), DATA_W/SEL_W constants, and a writeback-bundle struct typedef (valid, en, sel, data, dump, err).
- One sub-module, mem_timeout_ctr: a clear/enable counter with terminal-count output, width $clog2(TIMEOUT+1).

Test Plan:
- ALU op, result_in=16'h1234, reg_wr_sel_in=3'd5, reg_wr_en_in=1 -> next cycle valid_out=1, wb_data=16'h1234, wb_sel=5, wb_en=1, stall_out never 1.
- Load at addr 16'h0040, mem_done asserted 3 cycles after mem_req with mem_rdata=16'hBEEF:
  - mem_req is a 1-cycle pulse with mem_addr=16'h0040 and mem_wr=0.
  - stall_out is 1 from acceptance until the mem_done cycle inclusive-low.
  - Then valid_out=1, wb_data=16'hBEEF.
- Store 16'hA5A5 to 16'h0010, done after 1 cycle -> mem_wr=1, mem_wdata=16'hA5A5, valid_out=1 with wb_en=0.
- Load at 16'h0003 -> no mem_req; next cycle err_out=1, wb_en=0, no stall.
- Load with mem_done never asserted, TIMEOUT=15 -> stall for 15 WAIT cycles, then err_out=1, state IDLE. Repeat with mem_done arriving on the timeout cycle -> no error.
- Reset pulse mid-WAIT, then a late mem_done -> all outputs 0 and no valid_out. Dump instruction -> dump_out=1, then halted=1, stall_out held 1, subsequent valid_in ignored.
